// File: rtl/pipeline_stage_regs_pkg.sv
// rtl/pipeline_stage_regs_pkg.sv - shared constants for the pipeline stage registers
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Control bundle layout, MSB first: RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl[2:0], ALUSrc
  localparam int CTRL_REGWRITE_BIT  = 9;
  localparam int CTRL_RESULTSRC_LSB = 7;
  localparam int CTRL_MEMWRITE_BIT  = 6;
  localparam int CTRL_JUMP_BIT      = 5;
  localparam int CTRL_BRANCH_BIT    = 4;
  localparam int CTRL_ALUCTRL_LSB   = 1;
  localparam int CTRL_ALUSRC_BIT    = 0;

endpackage

// File: rtl/pipeline_stage_regs_if.sv
// rtl/pipeline_stage_regs_if.sv - hazard/datapath bundle between the core and its stage registers
interface pipeline_stage_regs_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int FORWARD_WIDTH = 2,
  parameter int CTRL_WIDTH    = 10,
  parameter int COUNT_WIDTH   = 32
);
  logic                     StallF, StallD, FlushD, FlushE;
  logic [FORWARD_WIDTH-1:0] ForwardAE, ForwardBE;
  logic [DATA_WIDTH-1:0]    PCNextF, PCF;
  logic [DATA_WIDTH-1:0]    InstrF, PCPlus4F;
  logic [DATA_WIDTH-1:0]    InstrD, PCD, PCPlus4D;
  logic [ADDRESS_WIDTH-1:0] Rs1D, Rs2D;
  logic [CTRL_WIDTH-1:0]    CtrlD, CtrlE;
  logic [DATA_WIDTH-1:0]    RD1D, RD2D, ImmExtD;
  logic [ADDRESS_WIDTH-1:0] RdD;
  logic [DATA_WIDTH-1:0]    PCE, PCPlus4E, ImmExtE;
  logic [ADDRESS_WIDTH-1:0] Rs1E, Rs2E, RdE;
  logic [DATA_WIDTH-1:0]    ALUResultM, ResultW;
  logic [DATA_WIDTH-1:0]    SrcAE, WriteDataE;
  logic [COUNT_WIDTH-1:0]   StallCount, FlushCount;

  modport master (
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, PCNextF,
           InstrF, PCPlus4F, CtrlD, RD1D, RD2D, ImmExtD, RdD, ALUResultM, ResultW,
    input  PCF, InstrD, PCD, PCPlus4D, Rs1D, Rs2D, CtrlE, PCE, PCPlus4E, ImmExtE,
           Rs1E, Rs2E, RdE, SrcAE, WriteDataE, StallCount, FlushCount
  );

  modport slave (
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, PCNextF,
           InstrF, PCPlus4F, CtrlD, RD1D, RD2D, ImmExtD, RdD, ALUResultM, ResultW,
    output PCF, InstrD, PCD, PCPlus4D, Rs1D, Rs2D, CtrlE, PCE, PCPlus4E, ImmExtE,
           Rs1E, Rs2E, RdE, SrcAE, WriteDataE, StallCount, FlushCount
  );
endinterface

// File: rtl/pipeline_stage_regs_pipe_reg.sv
// rtl/pipeline_stage_regs_pipe_reg.sv - enable/clear register; reset and clear both load CLEAR_VALUE
module pipe_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // clr outranks en so a flush always beats a stall
  always_ff @(posedge clk) begin
    if (!rst_n)
      q <= CLEAR_VALUE;
    else if (clr)
      q <= CLEAR_VALUE;
    else if (en)
      q <= d;
  end
endmodule

// File: rtl/pipeline_stage_regs.sv
// rtl/pipeline_stage_regs.sv - PC, IF/ID and ID/EX registers with stall/flush, forwarding and event counters
module pipeline_stage_regs
  import pipeline_pkg::*;
#(
  parameter int              DATA_WIDTH    = 32,
  parameter int              ADDRESS_WIDTH = 5,
  parameter int              FORWARD_WIDTH = 2,
  parameter int              CTRL_WIDTH    = 10,
  parameter logic [31:0]     RESET_PC      = 32'h0000_0000,
  parameter int              COUNT_WIDTH   = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  pipeline_stage_regs_if.slave bus
);
  localparam int IFID_W = 3 * DATA_WIDTH;
  localparam int IDEX_W = CTRL_WIDTH + 5 * DATA_WIDTH + 3 * ADDRESS_WIDTH;
  localparam logic [IFID_W-1:0] IFID_CLEAR = {NOP_INSTR, {(2 * DATA_WIDTH){1'b0}}};

  logic [DATA_WIDTH-1:0]    pcf;
  logic [DATA_WIDTH-1:0]    instr_d, pc_d, pc4_d;
  logic [ADDRESS_WIDTH-1:0] rs1_d, rs2_d;
  logic [CTRL_WIDTH-1:0]    ctrl_e;
  logic [DATA_WIDTH-1:0]    rd1_e, rd2_e, pc_e, pc4_e, imm_e;
  logic [ADDRESS_WIDTH-1:0] rs1_e, rs2_e, rd_e;
  logic [COUNT_WIDTH-1:0]   stall_count, flush_count;

  pipe_reg #(.WIDTH(DATA_WIDTH), .CLEAR_VALUE(RESET_PC[DATA_WIDTH-1:0])) u_pc_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (!bus.StallF),
    .clr  (1'b0),
    .d    (bus.PCNextF),
    .q    (pcf)
  );

  pipe_reg #(.WIDTH(IFID_W), .CLEAR_VALUE(IFID_CLEAR)) u_ifid_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (!bus.StallD),
    .clr  (bus.FlushD),
    .d    ({bus.InstrF, pcf, bus.PCPlus4F}),
    .q    ({instr_d, pc_d, pc4_d})
  );

  assign rs1_d = instr_d[19:15];
  assign rs2_d = instr_d[24:20];

  // ID/EX never stalls: a load-use hazard arrives here as FlushE
  pipe_reg #(.WIDTH(IDEX_W), .CLEAR_VALUE({IDEX_W{1'b0}})) u_idex_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (1'b1),
    .clr  (bus.FlushE),
    .d    ({bus.CtrlD, bus.RD1D, bus.RD2D, pc_d, pc4_d, bus.ImmExtD, rs1_d, rs2_d, bus.RdD}),
    .q    ({ctrl_e, rd1_e, rd2_e, pc_e, pc4_e, imm_e, rs1_e, rs2_e, rd_e})
  );

  // Reserved select 2'b11 falls through to the register-file operand
  always_comb begin
    bus.SrcAE = rd1_e;
    case (bus.ForwardAE)
      FWD_W:   bus.SrcAE = bus.ResultW;
      FWD_M:   bus.SrcAE = bus.ALUResultM;
      default: bus.SrcAE = rd1_e;
    endcase
  end

  always_comb begin
    bus.WriteDataE = rd2_e;
    case (bus.ForwardBE)
      FWD_W:   bus.WriteDataE = bus.ResultW;
      FWD_M:   bus.WriteDataE = bus.ALUResultM;
      default: bus.WriteDataE = rd2_e;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (bus.StallF && (stall_count != {COUNT_WIDTH{1'b1}}))
        stall_count <= stall_count + 1'b1;
      if (bus.FlushE && (flush_count != {COUNT_WIDTH{1'b1}}))
        flush_count <= flush_count + 1'b1;
    end
  end

  assign bus.PCF        = pcf;
  assign bus.InstrD     = instr_d;
  assign bus.PCD        = pc_d;
  assign bus.PCPlus4D   = pc4_d;
  assign bus.Rs1D       = rs1_d;
  assign bus.Rs2D       = rs2_d;
  assign bus.CtrlE      = ctrl_e;
  assign bus.PCE        = pc_e;
  assign bus.PCPlus4E   = pc4_e;
  assign bus.ImmExtE    = imm_e;
  assign bus.Rs1E       = rs1_e;
  assign bus.Rs2E       = rs2_e;
  assign bus.RdE        = rd_e;
  assign bus.StallCount = stall_count;
  assign bus.FlushCount = flush_count;
endmodule

// File: tb/tb_pipeline_stage_regs.sv
// tb/tb_pipeline_stage_regs.sv - directed and randomized checks of pipeline_stage_regs against a reference model
module tb_pipeline_stage_regs;
  localparam int CW = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  pipeline_stage_regs_if #(.COUNT_WIDTH(CW)) bus ();

  pipeline_stage_regs #(.RESET_PC(RPC), .COUNT_WIDTH(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: one variable per architectural register
  logic [31:0] m_pcf, m_instr_d, m_pcd, m_pc4d;
  logic [9:0]  m_ctrl_e;
  logic [31:0] m_rd1e, m_rd2e, m_pce, m_pc4e, m_imme;
  logic [4:0]  m_rs1e, m_rs2e, m_rde;
  int          m_stall_cnt, m_flush_cnt;

  function automatic logic [31:0] fwd(logic [1:0] sel, logic [31:0] rf, logic [31:0] w, logic [31:0] m);
    if (sel == 2'd1) return w;
    if (sel == 2'd2) return m;
    return rf;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".PCF"}, bus.PCF, m_pcf);
    check({tag, ".InstrD"}, bus.InstrD, m_instr_d);
    check({tag, ".PCD"}, bus.PCD, m_pcd);
    check({tag, ".PCPlus4D"}, bus.PCPlus4D, m_pc4d);
    check({tag, ".Rs1D"}, 32'(bus.Rs1D), 32'((m_instr_d >> 15) & 32'h1f));
    check({tag, ".Rs2D"}, 32'(bus.Rs2D), 32'((m_instr_d >> 20) & 32'h1f));
    check({tag, ".CtrlE"}, 32'(bus.CtrlE), 32'(m_ctrl_e));
    check({tag, ".PCE"}, bus.PCE, m_pce);
    check({tag, ".PCPlus4E"}, bus.PCPlus4E, m_pc4e);
    check({tag, ".ImmExtE"}, bus.ImmExtE, m_imme);
    check({tag, ".Rs1E"}, 32'(bus.Rs1E), 32'(m_rs1e));
    check({tag, ".Rs2E"}, 32'(bus.Rs2E), 32'(m_rs2e));
    check({tag, ".RdE"}, 32'(bus.RdE), 32'(m_rde));
    check({tag, ".SrcAE"}, bus.SrcAE, fwd(bus.ForwardAE, m_rd1e, bus.ResultW, bus.ALUResultM));
    check({tag, ".WriteDataE"}, bus.WriteDataE, fwd(bus.ForwardBE, m_rd2e, bus.ResultW, bus.ALUResultM));
    check({tag, ".StallCount"}, 32'(bus.StallCount), 32'(m_stall_cnt));
    check({tag, ".FlushCount"}, 32'(bus.FlushCount), 32'(m_flush_cnt));
  endtask

  // Advance one edge and update the model from the inputs held across that edge
  task automatic tick();
    logic [31:0] old_pcf, old_instr, old_pcd, old_pc4d;
    @(posedge clk);
    old_pcf = m_pcf; old_instr = m_instr_d; old_pcd = m_pcd; old_pc4d = m_pc4d;
    if (!rst_n) begin
      m_pcf = RPC; m_instr_d = NOP; m_pcd = 0; m_pc4d = 0;
      m_ctrl_e = 0; m_rd1e = 0; m_rd2e = 0; m_pce = 0; m_pc4e = 0; m_imme = 0;
      m_rs1e = 0; m_rs2e = 0; m_rde = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      if (!bus.StallF) m_pcf = bus.PCNextF;
      if (bus.FlushD) begin
        m_instr_d = NOP; m_pcd = 0; m_pc4d = 0;
      end else if (!bus.StallD) begin
        m_instr_d = bus.InstrF; m_pcd = old_pcf; m_pc4d = bus.PCPlus4F;
      end
      if (bus.FlushE) begin
        m_ctrl_e = 0; m_rd1e = 0; m_rd2e = 0; m_pce = 0; m_pc4e = 0; m_imme = 0;
        m_rs1e = 0; m_rs2e = 0; m_rde = 0;
      end else begin
        m_ctrl_e = bus.CtrlD; m_rd1e = bus.RD1D; m_rd2e = bus.RD2D; m_pce = old_pcd;
        m_pc4e = old_pc4d; m_imme = bus.ImmExtD;
        m_rs1e = old_instr[19:15]; m_rs2e = old_instr[24:20]; m_rde = bus.RdD;
      end
      if (bus.StallF && m_stall_cnt < CMAX) m_stall_cnt++;
      if (bus.FlushE && m_flush_cnt < CMAX) m_flush_cnt++;
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.StallF = 0; bus.StallD = 0; bus.FlushD = 0; bus.FlushE = 0;
    bus.ForwardAE = 0; bus.ForwardBE = 0;
  endtask

  initial begin
    logic [31:0] exp_a [4];
    exp_a[0] = 5; exp_a[1] = 9; exp_a[2] = 7; exp_a[3] = 5;
    m_pcf = 'x; m_instr_d = 'x; m_pcd = 'x; m_pc4d = 'x;
    rst_n = 0;
    idle_inputs();
    bus.PCNextF = 32'h4; bus.InstrF = 0; bus.PCPlus4F = 0; bus.CtrlD = 10'h3ff;
    bus.RD1D = 0; bus.RD2D = 0; bus.ImmExtD = 0; bus.RdD = 0;
    bus.ALUResultM = 0; bus.ResultW = 0;

    tick(); tick();
    check("reset.PCF", bus.PCF, RPC);
    check("reset.InstrD", bus.InstrD, NOP);
    check("reset.CtrlE", 32'(bus.CtrlE), 32'h0);
    check("reset.StallCount", 32'(bus.StallCount), 32'h0);
    check("reset.FlushCount", 32'(bus.FlushCount), 32'h0);
    check_all("reset");

    rst_n = 1; bus.CtrlD = 10'h155;
    tick();
    check("release.PCF", bus.PCF, 32'h4);
    check_all("release");

    // Load-use: stall fetch/decode with a bubble into execute
    bus.InstrF = 32'h00A00093; bus.PCPlus4F = 32'h8; bus.PCNextF = 32'h8;
    tick();
    bus.InstrF = 32'h0041_0113; bus.PCNextF = 32'hC;
    bus.StallF = 1; bus.StallD = 1; bus.FlushE = 1;
    tick();
    check("lu.PCF", bus.PCF, 32'h8);
    check("lu.InstrD", bus.InstrD, 32'h00A00093);
    check("lu.CtrlE", 32'(bus.CtrlE), 32'h0);
    check("lu.StallCount", 32'(bus.StallCount), 32'h1);
    check("lu.FlushCount", 32'(bus.FlushCount), 32'h1);
    check_all("lu");

    // Branch flush
    idle_inputs();
    bus.InstrF = 32'h00208133; bus.FlushD = 1; bus.FlushE = 1;
    tick();
    check("br.InstrD", bus.InstrD, NOP);
    check("br.CtrlE", 32'(bus.CtrlE), 32'h0);
    check_all("br");
    idle_inputs();
    bus.InstrF = 32'h0030_81B3;
    tick();
    check("br_next.InstrD", bus.InstrD, 32'h0030_81B3);
    check_all("br_next");

    // Forwarding on a freshly loaded execute stage
    bus.RD1D = 5; bus.RD2D = 5;
    tick();
    bus.ALUResultM = 7; bus.ResultW = 9;
    for (int s = 0; s < 4; s++) begin
      bus.ForwardAE = 2'(s); bus.ForwardBE = 2'(3 - s);
      #1;
      check($sformatf("fwdA%0d", s), bus.SrcAE, exp_a[s]);
      check($sformatf("fwdB%0d", 3 - s), bus.WriteDataE, exp_a[3 - s]);
    end
    idle_inputs();

    // Priority: flush beats stall; reset beats everything
    bus.StallD = 1; bus.FlushD = 1;
    tick();
    check("prio.InstrD", bus.InstrD, NOP);
    bus.FlushD = 0; bus.StallF = 1; bus.PCNextF = 32'h100;
    tick();
    bus.StallF = 1; bus.FlushD = 1;
    tick();
    check("stallF_flushD.InstrD", bus.InstrD, NOP);
    check_all("stallF_flushD");
    rst_n = 0; bus.FlushE = 1;
    tick();
    check("rst_mid.PCF", bus.PCF, RPC);
    check_all("rst_mid");
    rst_n = 1;
    idle_inputs();

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      bus.StallF = ($urandom_range(0, 3) == 0);
      bus.StallD = ($urandom_range(0, 3) == 0);
      bus.FlushD = ($urandom_range(0, 4) == 0);
      bus.FlushE = ($urandom_range(0, 4) == 0);
      bus.ForwardAE = 2'($urandom); bus.ForwardBE = 2'($urandom);
      bus.PCNextF = $urandom; bus.InstrF = $urandom; bus.PCPlus4F = $urandom;
      bus.CtrlD = 10'($urandom); bus.RD1D = $urandom; bus.RD2D = $urandom;
      bus.ImmExtD = $urandom; bus.RdD = 5'($urandom);
      bus.ALUResultM = $urandom; bus.ResultW = $urandom;
      tick();
      check_all($sformatf("rand%0d", i));
    end
    rst_n = 1;
    idle_inputs();

    // Saturation: drive StallCount to all-ones, then keep stalling
    bus.StallF = 1;
    for (int i = 0; i < CMAX; i++) tick();
    check("sat.StallCount", 32'(bus.StallCount), 32'(CMAX));
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("sat_hold%0d", i), 32'(bus.StallCount), 32'(CMAX));
    end
    check_all("sat");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_stage_regs.md
# pipeline_stage_regs

Consumer side of the hazard unit's stall/flush/forward controls for the 5-stage RISC-V core. Holds the fetch PC register, the IF/ID register and the ID/EX register, and applies StallF/StallD/FlushD/FlushE to them. Drives Rs1D/Rs2D/RdE/Rs1E/Rs2E back to the hazard unit and applies ForwardAE/ForwardBE to the execute-stage operands. Also keeps saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath/PC/instruction width
- ADDRESS_WIDTH, 5, register index width
- FORWARD_WIDTH, 2, forward select width
- CTRL_WIDTH, 10, packed decode control bundle width (RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl, ALUSrc)
- RESET_PC, 32'h0000_0000, PCF value after reset
- COUNT_WIDTH, 32, event counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous and active-low
- StallF, StallD  in  1  active-high hold of the PC and IF/ID registers
- FlushD, FlushE  in  1  active-high bubble insertion into IF/ID and ID/EX
- ForwardAE, ForwardBE  in  FORWARD_WIDTH  execute-operand select
- PCNextF  in  DATA_WIDTH  next PC from the fetch mux
- PCF  out  DATA_WIDTH  current fetch PC
- InstrF, PCPlus4F  in  DATA_WIDTH  fetch-stage values
- InstrD, PCD, PCPlus4D  out  DATA_WIDTH  decode-stage values
- Rs1D, Rs2D  out  ADDRESS_WIDTH  InstrD[19:15], InstrD[24:20]
- CtrlD  in  CTRL_WIDTH  decoded control bundle
- RD1D, RD2D, ImmExtD  in  DATA_WIDTH  register file reads and immediate
- RdD  in  ADDRESS_WIDTH  InstrD[11:7] from the decoder
- CtrlE  out  CTRL_WIDTH  registered control
- PCE, PCPlus4E, ImmExtE  out  DATA_WIDTH  registered data
- Rs1E, Rs2E, RdE  out  ADDRESS_WIDTH  registered indices
- ALUResultM, ResultW  in  DATA_WIDTH  forwarding sources
- SrcAE, WriteDataE  out  DATA_WIDTH  forwarded operands A and B
- StallCount, FlushCount  out  COUNT_WIDTH  event counters

## Operation
- PC register: rst_n=0 loads RESET_PC. StallF=1 holds. Otherwise PCF<=PCNextF.
- IF/ID register, priority rst_n=0 > FlushD > StallD > load:
  - Reset and flush load InstrD=NOP (32'h0000_0013), PCD=0, PCPlus4D=0.
  - Stall holds all fields.
  - Load captures InstrF, PCF, PCPlus4F.
- ID/EX register, priority rst_n=0 > FlushE > load:
  - Reset and flush clear every field to 0, including CtrlE. This is the bubble: RegWrite=0, MemWrite=0, Branch=0, Jump=0.
  - There is no stall input for ID/EX. A load-use stall is expressed as FlushE.
- Forwarding, combinational on ForwardXE:
  - 2'b00 selects RD1E/RD2E.
  - 2'b01 selects ResultW.
  - 2'b10 selects ALUResultM.
  - 2'b11 is reserved and selects RD1E/RD2E.
- StallCount increments in every cycle with StallF=1. FlushCount increments in every cycle with FlushE=1.
  - Both counters saturate at all-ones and do not wrap.
  - Both reset to 0 and have no other clear.
- Simultaneous events:
  - FlushD=1 with StallD=1: flush wins and a NOP is loaded.
  - StallF=1 with FlushD=1: PC holds and IF/ID flushes. The hazard unit never produces lwstall with PCSrcE; the bench still checks this defined behaviour.
- Reset mid-operation: the next edge with rst_n=0 overrides every stall and flush. All registers take their reset values on that edge.

## Timing
- Each register stage has 1-cycle latency. Values captured at edge N are visible after edge N.
- Rs1D, Rs2D, SrcAE and WriteDataE are combinational from register outputs and inputs, with no added latency. The hazard unit loop is combinational by design.
- Reset values:
  - PCF=RESET_PC, InstrD=NOP, all other D outputs 0.
  - All E outputs 0.
  - Counters 0.
  - Rs1D=0 and Rs2D=0 (NOP fields).
- A stall holds for exactly the number of cycles it is asserted. Release resumes loading on the first edge with the stall deasserted.

## Structure
- Package pipeline_pkg holds:
  - NOP_INSTR.
  - Forward select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - The CTRL_WIDTH field offsets.
- Sub-module pipe_reg: parameterized WIDTH and CLEAR_VALUE, with inputs en and clr and synchronous active-low reset. It is instantiated for the PC, IF/ID and ID/EX registers.
- Forward muxes and counters are coded inline.

## Test plan
- Reset and load:
  - Hold rst_n=0 for 2 edges: PCF=0, InstrD=32'h13, CtrlE=0, counters 0.
  - Release with PCNextF=4: PCF=4 after 1 edge.
- Load-use stall:
  - StallF=StallD=FlushE=1 for 1 cycle with InstrF=32'h00A00093 already in decode: PCF and InstrD hold, CtrlE=0.
  - StallCount=1 and FlushCount=1.
- Branch flush:
  - FlushD=FlushE=1 while InstrF=32'h00208133: next InstrD=32'h13 and CtrlE=0.
  - Following cycle loads normally.
- Forwarding:
  - RD1E=5, ALUResultM=7, ResultW=9.
  - ForwardAE=00/01/10/11 gives SrcAE=5/9/7/5. Repeat for ForwardBE and WriteDataE.
- Priority:
  - StallD=1 with FlushD=1 gives InstrD=NOP.
  - rst_n=0 during an active stall resets PCF to RESET_PC on that edge.
- Saturation: force StallCount to all-ones, assert StallF for 3 cycles: the counter stays all-ones.
